// File: rtl/irq_ctrl_if.sv
// Register port and core interrupt handshake between irq_ctrl and the mcu0/system glue.
interface irq_ctrl_if;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       iack;
  logic       eoi;
  logic       interrupt;
  logic [2:0] irq;

  modport master (
    output wr, addr, wdata, iack, eoi,
    input  rdata, interrupt, irq
  );

  modport slave (
    input  wr, addr, wdata, iack, eoi,
    output rdata, interrupt, irq
  );
endinterface

// File: rtl/irq_ctrl.sv
// Eight-source priority interrupt controller driving the mcu0 interrupt/irq inputs.
// Requests are synchronized, latched, masked and presented one at a time until EOI.
module irq_ctrl #(
  parameter logic [7:0] EDGE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] src,
  irq_ctrl_if.slave  bus
);
  // state   | meaning
  // IDLE    | nothing presented, waiting for an enabled pending source
  // ASSERT  | interrupt/irq committed to the core, waiting for iack
  // SERVICE | one source in service, waiting for eoi (no nesting)
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t     state;
  logic [7:0] s1, s2, s3;
  logic [7:0] mask, pending, inservice;
  logic [7:0] set_vec, clr_vec, candidate;
  logic [2:0] pick;
  logic       accept;

  always_comb begin
    accept  = (state == ASSERT) && bus.iack;
    set_vec = (EDGE & s2 & ~s3) | (~EDGE & s2);
    if (bus.wr && bus.addr == 2'd3) set_vec = set_vec | bus.wdata;
    clr_vec = '0;
    if (bus.wr && bus.addr == 2'd1) clr_vec = bus.wdata;
    if (accept) clr_vec = clr_vec | (8'd1 << bus.irq);
    candidate = pending & mask;
    pick = '0;
    for (int i = 7; i >= 0; i--) begin
      if (candidate[i]) pick = 3'(i);
    end
  end

  always_comb begin
    case (bus.addr)
      2'd0:    bus.rdata = mask;
      2'd1:    bus.rdata = pending;
      2'd2:    bus.rdata = inservice;
      default: bus.rdata = 8'h00;
    endcase
  end

  // set wins over clear so a level source that is still high stays pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      mask    <= '0;
      pending <= '0;
    end else begin
      s1      <= src;
      s2      <= s1;
      s3      <= s2;
      pending <= (pending & ~clr_vec) | set_vec;
      if (bus.wr && bus.addr == 2'd0) mask <= bus.wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.interrupt <= 1'b0;
      bus.irq       <= '0;
      inservice     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (candidate != 8'h00) begin
            bus.irq       <= pick;
            bus.interrupt <= 1'b1;
            state         <= ASSERT;
          end
        end
        ASSERT: begin
          if (bus.iack) begin
            inservice     <= 8'd1 << bus.irq;
            bus.interrupt <= 1'b0;
            state         <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            inservice <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus predicts each presented vector and the edge it
// appears on; a negedge monitor pops and compares whenever interrupt rises.
module tb_irq_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] src = 8'h00;

  irq_ctrl_if bus ();

  irq_ctrl #(.EDGE(8'hFE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .src     (src),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int vec;
    int at;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_pending = 8'h00;
  logic [7:0] m_mask = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int prio(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic expect_present(input int at, output int v);
    v = prio(m_pending & m_mask);
    if (v >= 0) sb.push_back('{v, at});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d, output int e);
    bus.wr = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    e = cyc + 1;
    @(negedge clock);
    bus.wr = 1'b0;
    case (a)
      2'd0: m_mask = d;
      2'd1: m_pending = m_pending & ~d;
      2'd3: m_pending = m_pending | d;
      default: ;
    endcase
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic pulse(input bit do_iack, input bit do_eoi, output int e);
    bus.iack = do_iack;
    bus.eoi = do_eoi;
    e = cyc + 1;
    @(negedge clock);
    bus.iack = 1'b0;
    bus.eoi = 1'b0;
  endtask

  task automatic wait_int(input int budget);
    for (int k = 0; k < budget && !bus.interrupt; k++) @(negedge clock);
    chk("wait_interrupt", bus.interrupt, 1);
  endtask

  task automatic accept_irq(input int v, input bit with_eoi);
    int e;
    pulse(1'b1, with_eoi, e);
    m_pending[v] = 1'b0;
    chk("iack_drops_interrupt", bus.interrupt, 0);
    chk_reg("inservice_after_iack", 2'd2, 8'(1 << v));
  endtask

  task automatic finish_irq(input bit with_iack, output int v);
    int e;
    pulse(with_iack, 1'b1, e);
    expect_present(e + 1, v);
    chk_reg("inservice_after_eoi", 2'd2, 8'h00);
  endtask

  // Monitor: every rise of interrupt must match the oldest prediction.
  logic       prev_int = 1'b0;
  logic [2:0] held = '0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_int = 1'b0;
    end else begin
      if (bus.interrupt && !prev_int) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_interrupt: irq=%0d at edge %0d with no prediction", bus.irq, cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("present_vector", bus.irq, x.vec);
          chk("present_edge", cyc, x.at);
        end
        held = bus.irq;
      end else if (bus.interrupt) begin
        chk("irq_stable", bus.irq, held);
      end
      prev_int = bus.interrupt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, v;
    bit b1, b2;
    bus.wr = 1'b0;
    bus.addr = 2'd0;
    bus.wdata = 8'h00;
    bus.iack = 1'b0;
    bus.eoi = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_interrupt", bus.interrupt, 0);
    chk("rst_irq", bus.irq, 0);
    chk_reg("rst_mask", 2'd0, 8'h00);
    chk_reg("rst_pending", 2'd1, 8'h00);
    chk_reg("rst_inservice", 2'd2, 8'h00);
    chk_reg("rst_soft", 2'd3, 8'h00);
    reset_n = 1'b1;
    @(negedge clock);

    // external edge on src[5]
    wr_reg(2'd0, 8'hFF, e);
    src[5] = 1'b1;
    e = cyc + 1;
    sb.push_back('{5, e + 3});
    repeat (2) @(negedge clock);
    chk_reg("src_pending_early", 2'd1, 8'h00);
    @(negedge clock);
    chk_reg("src_pending", 2'd1, 8'h20);
    wait_int(5);
    src[5] = 1'b0;
    accept_irq(5, 1'b0);
    chk_reg("src_pending_cleared", 2'd1, 8'h00);
    finish_irq(1'b0, v);

    // priority between two soft requests
    wr_reg(2'd3, 8'h84, e);
    expect_present(e + 1, v);
    wait_int(5);
    accept_irq(v, 1'b0);
    finish_irq(1'b0, v);
    wait_int(5);
    accept_irq(v, 1'b0);
    finish_irq(1'b0, v);

    // masked source stays latent until enabled
    wr_reg(2'd0, 8'h00, e);
    wr_reg(2'd3, 8'h01, e);
    chk_reg("masked_pending", 2'd1, 8'h01);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("masked_no_interrupt", bus.interrupt, 0);
    end
    wr_reg(2'd0, 8'h01, e);
    expect_present(e + 1, v);
    wait_int(5);
    accept_irq(v, 1'b0);
    finish_irq(1'b0, v);

    // committed request survives W1C and mask removal
    wr_reg(2'd0, 8'hFF, e);
    wr_reg(2'd3, 8'h08, e);
    expect_present(e + 1, v);
    wait_int(5);
    wr_reg(2'd1, 8'h08, e);
    wr_reg(2'd0, 8'h00, e);
    repeat (3) @(negedge clock);
    chk("committed_interrupt", bus.interrupt, 1);
    chk("committed_irq", bus.irq, 3);
    chk_reg("committed_pending", 2'd1, 8'h00);
    accept_irq(3, 1'b0);
    finish_irq(1'b0, v);

    // level source src[0] held high
    wr_reg(2'd0, 8'h01, e);
    src[0] = 1'b1;
    e = cyc + 1;
    sb.push_back('{0, e + 3});
    wait_int(6);
    for (int r = 0; r < 2; r++) begin
      accept_irq(0, 1'b0);
      chk_reg("level_still_pending", 2'd1, 8'h01);
      wr_reg(2'd1, 8'h01, e);
      chk_reg("level_w1c_no_effect", 2'd1, 8'h01);
      pulse(1'b0, 1'b1, e);
      sb.push_back('{0, e + 1});
      wait_int(5);
    end
    src[0] = 1'b0;
    repeat (3) @(negedge clock);
    accept_irq(0, 1'b0);
    chk_reg("level_released", 2'd1, 8'h00);
    m_pending = 8'h00;
    finish_irq(1'b0, v);
    repeat (3) @(negedge clock);

    // randomized soft requests under random masks
    for (int r = 0; r < 12; r++) begin
      wr_reg(2'd0, 8'($urandom_range(1, 255)), e);
      wr_reg(2'd3, 8'($urandom_range(1, 255)), e);
      expect_present(e + 1, v);
      while (v >= 0) begin
        wait_int(5);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        b1 = 1'($urandom_range(0, 1));
        accept_irq(v, b1);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        b2 = 1'($urandom_range(0, 1));
        finish_irq(b2, v);
      end
      chk_reg("rand_leftover_pending", 2'd1, m_pending);
      wr_reg(2'd1, 8'hFF, e);
      chk_reg("rand_pending_cleared", 2'd1, 8'h00);
    end

    // reset while asserting drops interrupt at once
    wr_reg(2'd0, 8'hFF, e);
    wr_reg(2'd3, 8'h40, e);
    expect_present(e + 1, v);
    wait_int(5);
    #2 reset_n = 1'b0;
    #1 chk("reset_assert_drop", bus.interrupt, 0);
    @(negedge clock);
    reset_n = 1'b1;
    m_pending = 8'h00;
    m_mask = 8'h00;
    chk_reg("reset_assert_mask", 2'd0, 8'h00);

    // reset while in service
    wr_reg(2'd0, 8'hFF, e);
    wr_reg(2'd3, 8'h12, e);
    expect_present(e + 1, v);
    wait_int(5);
    accept_irq(v, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("reset_service_interrupt", bus.interrupt, 0);
    chk_reg("reset_service_mask", 2'd0, 8'h00);
    chk_reg("reset_service_pending", 2'd1, 8'h00);
    chk_reg("reset_service_inservice", 2'd2, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    m_pending = 8'h00;
    m_mask = 8'h00;
    @(negedge clock);

    // iack/eoi in IDLE are ignored
    wr_reg(2'd0, 8'hFF, e);
    pulse(1'b1, 1'b0, e);
    pulse(1'b0, 1'b1, e);
    pulse(1'b1, 1'b1, e);
    chk("idle_ack_interrupt", bus.interrupt, 0);
    chk_reg("idle_ack_inservice", 2'd2, 8'h00);
    chk_reg("idle_ack_pending", 2'd1, 8'h00);
    wr_reg(2'd3, 8'h01, e);
    expect_present(e + 1, v);
    wait_int(5);
    accept_irq(v, 1'b0);
    finish_irq(1'b0, v);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
